contador_ad_param: RTL
======================

Name: contador_ad_param

Overview:
- Parametrised up/down wrap-around counter for date/time fields (day, month, year, hour, minute) in the clock-setting path.
- Stepped by PS/2 scancodes while its field is selected in the edit state; also stepped by cascade pulses from a neighbouring field counter.
- Filters PS/2 break (release) sequences and only counts on the rising edge of got_data.
- Emits carry/borrow pulses so field counters can be chained.

Parameters:
- N, 4, counter width in bits
- MIN, 1, lowest count value
- MAX, 12, highest count value; MIN < MAX <= 2^N-1
- RST_VAL, 1, value loaded at reset; MIN <= RST_VAL <= MAX
- EN_SEL, 1, value of en that selects this field (2 bits)
- ESTADO_EDIT, 8'h7D, estado code for edit mode
- KEY_UP, 8'h73, scancode that increments
- KEY_DN, 8'h72, scancode that decrements

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- estado  in  8  current system state code
- en  in  2  field selector
- Cambio  in  8  last received PS/2 scancode; valid while got_data is high
- got_data  in  1  PS/2 receiver data-valid; may stay high for many cycles
- inc_in  in  1  cascade increment, one-cycle pulse
- dec_in  in  1  cascade decrement, one-cycle pulse
- Cuenta  out  N  current count, registered
- carry  out  1  one-cycle pulse on MAX->MIN wrap
- borrow  out  1  one-cycle pulse on MIN->MAX wrap

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - Cuenta=RST_VAL, carry=0, borrow=0.
  - got_data_q=0, brk=0.
  - Reset is held through release; no step is taken in the cycle rst deasserts.
- Key event:
  - key_ev = got_data & ~got_data_q, where got_data_q is got_data registered.
  - got_data held high for many cycles gives exactly one event.
  - A new event needs got_data low for at least one cycle first.
- Break filter (always tracked, independent of selection):
  - Event with Cambio=8'hF0: set brk; no step.
  - Next event with brk=1: clear brk; no step (the released key's code is discarded).
  - Event with Cambio=8'hE0: no step; brk unchanged.
- Edit gating: edit = (en==EN_SEL) && (estado==ESTADO_EDIT).
  - kb_up = key_ev & edit & ~brk & (Cambio==KEY_UP)
  - kb_dn = key_ev & edit & ~brk & (Cambio==KEY_DN)
- Step requests:
  - up = kb_up | inc_in; dn = kb_dn | dec_in.
  - inc_in and dec_in act regardless of edit.
  - up and dn in the same cycle: no change, carry=borrow=0.
- Up step:
  - Cuenta==MAX: Cuenta<=MIN, carry<=1.
  - Cuenta>MAX or Cuenta<MIN: Cuenta<=MIN, no pulse.
  - Otherwise: Cuenta<=Cuenta+1.
- Down step:
  - Cuenta==MIN: Cuenta<=MAX, borrow<=1.
  - Cuenta out of range: Cuenta<=MIN, no pulse.
  - Otherwise: Cuenta<=Cuenta-1.
- Timing:
  - Latency: Cuenta changes at the first rising clk edge where got_data is sampled high (same edge that sets got_data_q), or the edge that samples inc_in/dec_in high.
  - carry/borrow are registered, high exactly one cycle, and coincide with the wrapped Cuenta value; cleared on every cycle without a wrap.
- No step: Cuenta holds.
- Arithmetic: N-bit unsigned; no intermediate overflow because MAX < 2^N.

Optional Feature:
- Macro: CONTADOR_AD_BCD_EN.
- Defined:
  - Adds outputs bcd_dec[3:0] and bcd_uni[3:0], the registered tens/units of Cuenta.
  - Updated on the same edge as Cuenta.
  - Reset to the digits of RST_VAL.
  - Requires MAX <= 99.
- Undefined: the ports and the conversion logic are absent.

Test Plan:
- Reset, then edit: rst=0 -> Cuenta=1. Release; en=1, estado=7D, Cambio=73, got_data high 5 cycles -> Cuenta=2 exactly once.
- Wrap up: Cuenta=12, event 73 -> Cuenta=1 with carry high one cycle. Cuenta=1, event 72 -> Cuenta=12 with borrow high one cycle.
- Break filter: events F0 then 73 -> Cuenta unchanged, brk cleared. Following 73 event -> +1.
- Gating: en=2 or estado=7C, event 73 -> no change. inc_in pulse in the same conditions -> +1.
- Simultaneous: kb_up and dec_in in the same cycle -> Cuenta unchanged, carry=borrow=0.
- Async reset mid-operation: rst low between clock edges while Cuenta=7 -> Cuenta=1 immediately, carry=0. With CONTADOR_AD_BCD_EN: Cuenta=11 -> bcd_dec=1, bcd_uni=1.

Source files
------------

// File: rtl/contador_ad_param.sv
// Parametrised up/down wrap-around counter for one date/time field, stepped by PS/2 keys
// in edit mode or by cascade pulses. Optional registered BCD digits under CONTADOR_AD_BCD_EN.
module contador_ad_param #(
    parameter int         N           = 4,
    parameter int         MIN         = 1,
    parameter int         MAX         = 12,
    parameter int         RST_VAL     = 1,
    parameter logic [1:0] EN_SEL      = 2'd1,
    parameter logic [7:0] ESTADO_EDIT = 8'h7D,
    parameter logic [7:0] KEY_UP      = 8'h73,
    parameter logic [7:0] KEY_DN      = 8'h72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   estado,
    input  logic [1:0]   en,
    input  logic [7:0]   Cambio,
    input  logic         got_data,
    input  logic         inc_in,
    input  logic         dec_in,
    output logic [N-1:0] Cuenta,
    output logic         carry,
    output logic         borrow
`ifdef CONTADOR_AD_BCD_EN
    ,
    output logic [3:0]   bcd_dec,
    output logic [3:0]   bcd_uni
`endif
);

    localparam logic [N-1:0] MIN_V = N'(MIN);
    localparam logic [N-1:0] MAX_V = N'(MAX);
    localparam logic [N-1:0] RST_V = N'(RST_VAL);

    localparam logic [7:0] CODE_BRK = 8'hF0;

    logic         got_data_q;
    logic         brk;
    logic         key_ev;
    logic         edit;
    logic         kb_up;
    logic         kb_dn;
    logic         up;
    logic         dn;
    logic [N-1:0] cuenta_nxt;
    logic         carry_nxt;
    logic         borrow_nxt;

    assign key_ev = got_data & ~got_data_q;
    assign edit   = (en == EN_SEL) && (estado == ESTADO_EDIT);
    assign kb_up  = key_ev & edit & ~brk & (Cambio == KEY_UP);
    assign kb_dn  = key_ev & edit & ~brk & (Cambio == KEY_DN);
    assign up     = kb_up | inc_in;
    assign dn     = kb_dn | dec_in;

    // Out-of-range values recover to MIN silently in either direction.
    always_comb begin
        cuenta_nxt = Cuenta;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (up && !dn) begin
            if (Cuenta == MAX_V) begin
                cuenta_nxt = MIN_V;
                carry_nxt  = 1'b1;
            end else if (Cuenta > MAX_V || Cuenta < MIN_V) begin
                cuenta_nxt = MIN_V;
            end else begin
                cuenta_nxt = Cuenta + N'(1);
            end
        end else if (dn && !up) begin
            if (Cuenta == MIN_V) begin
                cuenta_nxt = MAX_V;
                borrow_nxt = 1'b1;
            end else if (Cuenta > MAX_V || Cuenta < MIN_V) begin
                cuenta_nxt = MIN_V;
            end else begin
                cuenta_nxt = Cuenta - N'(1);
            end
        end
    end

    // The event after an F0 is the released key's code and is always swallowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got_data_q <= 1'b0;
            brk        <= 1'b0;
        end else begin
            got_data_q <= got_data;
            if (key_ev) begin
                if (brk) begin
                    brk <= 1'b0;
                end else if (Cambio == CODE_BRK) begin
                    brk <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Cuenta <= RST_V;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            Cuenta <= cuenta_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

`ifdef CONTADOR_AD_BCD_EN
    logic [3:0] bcd_dec_nxt;
    logic [3:0] bcd_uni_nxt;

    assign bcd_dec_nxt = 4'(32'(cuenta_nxt) / 32'd10);
    assign bcd_uni_nxt = 4'(32'(cuenta_nxt) % 32'd10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_dec <= 4'(RST_VAL / 10);
            bcd_uni <= 4'(RST_VAL % 10);
        end else begin
            bcd_dec <= bcd_dec_nxt;
            bcd_uni <= bcd_uni_nxt;
        end
    end
`endif

endmodule
